wishbone_rr_arbiter: RTL and testbench
======================================

// Module: wishbone_rr_arbiter
// PURPOSE
//  Round-robin arbiter that lets N_CTRL Wishbone controllers share one Wishbone device.
//  Grants one controller at a time. A grant is held for the whole bus cycle (while that controller holds cyc).
//  Muxes the granted controller's cyc/stb/we/dat to the device and routes the device's ack/err/rty/stall back to it.
//  Sits between the controller modports and a single device modport of the wishbone bus.
// PARAMETERS
//  N_CTRL     4    number of requesting controllers (>=2)
//  DAT_WIDTH  8    data width, matches the wishbone bus DAT_WIDTH
//  TIMEOUT    255  watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN, >=1)
// PORTS
//  clk_i      in   1                  bus clock
//  rst_ni     in   1                  reset, asynchronous, active-low
//  c_cyc_i    in   N_CTRL             per-controller cyc
//  c_stb_i    in   N_CTRL             per-controller stb
//  c_we_i     in   N_CTRL             per-controller we
//  c_dat_i    in   N_CTRL*DAT_WIDTH   per-controller dat, controller k at [k*DAT_WIDTH +: DAT_WIDTH]
//  c_ack_o    out  N_CTRL             per-controller ack
//  c_err_o    out  N_CTRL             per-controller err
//  c_rty_o    out  N_CTRL             per-controller rty
//  c_stall_o  out  N_CTRL             per-controller stall
//  d_cyc_o    out  1                  to device: cyc
//  d_stb_o    out  1                  to device: stb
//  d_we_o     out  1                  to device: we
//  d_dat_o    out  DAT_WIDTH          to device: dat
//  d_ack_i    in   1                  from device: ack
//  d_err_i    in   1                  from device: err
//  d_rty_i    in   1                  from device: rty
//  d_stall_i  in   1                  from device: stall
//  grant_o    out  N_CTRL             one-hot current grantee; all zero when no grant is active
// BEHAVIOUR
//  Reset (rst_ni low, takes effect immediately):
//   - state=IDLE, last=N_CTRL-1, grant_o=0
//   - d_cyc/stb/we/dat=0
//   - c_ack/err/rty=0, c_stall=all 1s
//  Reset mid-cycle drops d_cyc_o at once; no completion is reported to the controller.
//  State IDLE:
//   - all device outputs 0; all c_stall=1
//   - search c_cyc_i starting at index (last+1) mod N_CTRL, wrapping
//   - first hit g is registered: grant_o=onehot(g), last=g, next state GRANT
//   - no request: stay in IDLE
//  State GRANT:
//   - d_cyc/stb/we/dat = controller g's inputs, combinational pass-through
//   - c_ack/err/rty/stall[g] = d_ack/err/rty/stall_i, combinational
//   - every other controller: ack/err/rty=0, stall=1
//   - when c_cyc_i[g]==0 (sampled at the clock edge): next state IDLE, grant_o=0
//  Latency and spacing:
//   - 1 clock from cyc rise in IDLE to grant; controllers stay stalled until the grant
//   - at least 1 IDLE cycle between consecutive grants
//  Fairness:
//   - the pointer advances only on a grant
//   - a continuously requesting controller waits at most N_CTRL-1 bus cycles
//  Simultaneous events:
//   - cyc requests arriving in the same cycle are resolved purely by pointer order
//   - a new request that arrives while the grantee releases cyc is served in the next IDLE evaluation
//  Single requester: re-granted after every IDLE cycle.
//  Device ack/err/rty are never forwarded while in IDLE.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - 8..16-bit watchdog counter wdt; cleared on entry to GRANT and on any d_ack/err/rty_i
//   - otherwise increments each GRANT cycle
//   - when wdt==TIMEOUT: c_err_o[g]=1 for exactly 1 cycle; next state ABORT
//  State ABORT:
//   - d_cyc_o=d_stb_o=0; c_stall[g]=1; device responses dropped
//   - ABORT -> IDLE once c_cyc_i[g]==0
//  WB_ARB_TIMEOUT_EN undefined:
//   - no counter and no ABORT state; TIMEOUT is ignored
//   - a hung device holds the grant indefinitely
// TESTING
//  1 Reset: pulse rst_ni low mid-GRANT -> d_cyc_o=0 and c_stall_o=4'b1111 in the same cycle; after release, grant_o=0
//  2 Round-robin: c_cyc_i=4'b1111 held, each grantee drops cyc after 1 ack -> grant_o sequence 0001,0010,0100,1000,0001
//  3 Routing: controller 2 granted, c_dat=8'hA5, we=1, device acks -> d_dat_o=8'hA5, d_we_o=1, c_ack_o=4'b0100 only
//  4 Handover: ctrl 1 drops cyc while ctrl 3 raises it -> 1 IDLE cycle with d_cyc_o=0, then grant_o=4'b1000
//  5 Stall passthrough: device d_stall_i=1 for 3 cycles -> granted c_stall_o high 3 cycles, others high throughout
//  6 Timeout (macro on, TIMEOUT=4): device never responds -> err pulse to grantee on cycle 5 of GRANT, d_cyc_o=0 until grantee drops cyc

Source files
------------

// File: rtl/wishbone_rr_arbiter_if.sv
// Signal bundle between N_CTRL Wishbone controllers, the round-robin arbiter and one shared device.
// The master modport is the arbiter's view. The slave modport is the surrounding controllers and device.
interface wishbone_rr_arbiter_if #(
  parameter int N_CTRL    = 4,
  parameter int DAT_WIDTH = 8
);
  logic [N_CTRL-1:0]                c_cyc_i, c_stb_i, c_we_i;
  logic [N_CTRL-1:0][DAT_WIDTH-1:0] c_dat_i;
  logic [N_CTRL-1:0]                c_ack_o, c_err_o, c_rty_o, c_stall_o;
  logic                             d_cyc_o, d_stb_o, d_we_o;
  logic [DAT_WIDTH-1:0]             d_dat_o;
  logic                             d_ack_i, d_err_i, d_rty_i, d_stall_i;

  modport master (
    input  c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_stall_i,
    output c_ack_o, c_err_o, c_rty_o, c_stall_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o
  );

  modport slave (
    output c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_stall_i,
    input  c_ack_o, c_err_o, c_rty_o, c_stall_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o
  );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_CTRL controllers share one device, and a grant lasts a whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a cycle after TIMEOUT cycles without a device response.

module wb_arb_lane (
  input  logic sel_i,
  input  logic err_inj_i,
  input  logic d_ack_i,
  input  logic d_err_i,
  input  logic d_rty_i,
  input  logic d_stall_i,
  output logic ack_o,
  output logic err_o,
  output logic rty_o,
  output logic stall_o
);
  // Unselected controllers see no responses and a permanent stall.
  assign ack_o   = sel_i & d_ack_i;
  assign err_o   = (sel_i & d_err_i) | err_inj_i;
  assign rty_o   = sel_i & d_rty_i;
  assign stall_o = ~sel_i | d_stall_i;
endmodule

module wishbone_rr_arbiter #(
  parameter int N_CTRL    = 4,
  parameter int DAT_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wishbone_rr_arbiter_if.master bus,
  output logic [N_CTRL-1:0]     grant_o
);
  localparam int IDX_W = $clog2(N_CTRL);

  if (N_CTRL < 2) begin : g_bad_n_ctrl
    $error("wishbone_rr_arbiter: N_CTRL must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wishbone_rr_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    GRANT
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d, nxt;
  logic [N_CTRL-1:0] grant_q, grant_d;
  logic [N_CTRL-1:0] route, err_inj;
  logic [N_CTRL-1:0] c_ack, c_err, c_rty, c_stall;
  logic              hit, timeout;

  // Search starts just past the last grantee and wraps, so each requester is at most N_CTRL-1 grants away.
  always_comb begin
    hit = 1'b0;
    nxt = last_q;
    for (int i = 1; i <= N_CTRL; i++) begin
      if (!hit && bus.c_cyc_i[(int'(last_q) + i) % N_CTRL]) begin
        hit = 1'b1;
        nxt = IDX_W'((int'(last_q) + i) % N_CTRL);
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WDT_W = (TIMEOUT > 255) ? 16 : 8;
  logic [WDT_W-1:0] wdt_q;

  assign timeout = (state_q == GRANT) && (wdt_q == WDT_W'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                           wdt_q <= '0;
    else if (state_q != GRANT || bus.d_ack_i || bus.d_err_i || bus.d_rty_i) wdt_q <= '0;
    else                                                   wdt_q <= wdt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: if (hit) begin
        state_d      = GRANT;
        last_d       = nxt;
        grant_d      = '0;
        grant_d[nxt] = 1'b1;
      end
      GRANT: begin
        if (!bus.c_cyc_i[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout) state_d = ABORT;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: if (!bus.c_cyc_i[last_q]) begin
        state_d = IDLE;
        grant_d = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_CTRL - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;

  // The device sees only the grantee, and only while in GRANT. In abort, cyc drops before the controller does.
  always_comb begin
    bus.d_cyc_o = 1'b0;
    bus.d_stb_o = 1'b0;
    bus.d_we_o  = 1'b0;
    bus.d_dat_o = '0;
    if (state_q == GRANT) begin
      bus.d_cyc_o = bus.c_cyc_i[last_q];
      bus.d_stb_o = bus.c_stb_i[last_q];
      bus.d_we_o  = bus.c_we_i[last_q];
      bus.d_dat_o = bus.c_dat_i[last_q];
    end
  end

  assign route   = (state_q == GRANT) ? grant_q : '0;
  assign err_inj = timeout ? grant_q : '0;

  for (genvar k = 0; k < N_CTRL; k++) begin : g_lane
    wb_arb_lane u_lane (
      .sel_i    (route[k]),
      .err_inj_i(err_inj[k]),
      .d_ack_i  (bus.d_ack_i),
      .d_err_i  (bus.d_err_i),
      .d_rty_i  (bus.d_rty_i),
      .d_stall_i(bus.d_stall_i),
      .ack_o    (c_ack[k]),
      .err_o    (c_err[k]),
      .rty_o    (c_rty[k]),
      .stall_o  (c_stall[k])
    );
  end

  assign bus.c_ack_o   = c_ack;
  assign bus.c_err_o   = c_err;
  assign bus.c_rty_o   = c_rty;
  assign bus.c_stall_o = c_stall;
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: directed scenarios plus random traffic, checked every cycle against a grantee/pointer model.
module tb_wishbone_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] grant;
  logic [N-1:0] rr_exp [5];

  wishbone_rr_arbiter_if #(.N_CTRL(N), .DAT_WIDTH(DW)) bus ();

  wishbone_rr_arbiter #(.N_CTRL(N), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: who owns the bus, whether it is being aborted, the round-robin pointer and the idle-response age.
  bit m_busy, m_abort;
  int m_g, m_last, m_wdt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_timeout();
`ifdef WB_ARB_TIMEOUT_EN
    return m_busy && !m_abort && m_wdt == TO;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_last = N - 1; m_g = 0; m_wdt = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  gmask, e_stall;
    logic [DW-1:0] e_dat;
    bit live;
    live    = m_busy && !m_abort;
    gmask   = m_busy ? N'(1 << m_g) : '0;
    e_dat   = live ? bus.c_dat_i[m_g] : '0;
    e_stall = live ? (~gmask | (bus.d_stall_i ? gmask : '0)) : '1;
    chk("grant", grant, gmask);
    chk("d_cyc", bus.d_cyc_o, live && bus.c_cyc_i[m_g]);
    chk("d_stb", bus.d_stb_o, live && bus.c_stb_i[m_g]);
    chk("d_we", bus.d_we_o, live && bus.c_we_i[m_g]);
    chk("d_dat", bus.d_dat_o, e_dat);
    chk("c_ack", bus.c_ack_o, (live && bus.d_ack_i) ? gmask : '0);
    chk("c_err", bus.c_err_o, (live && (bus.d_err_i || m_timeout())) ? gmask : '0);
    chk("c_rty", bus.c_rty_o, (live && bus.d_rty_i) ? gmask : '0);
    chk("c_stall", bus.c_stall_o, e_stall);
  endtask

  task automatic model_step();
    if (!m_busy) begin
      for (int i = 1; i <= N; i++) begin
        if (bus.c_cyc_i[(m_last + i) % N]) begin
          m_busy = 1; m_g = (m_last + i) % N; m_last = m_g; m_wdt = 0;
          break;
        end
      end
    end else if (m_abort) begin
      if (!bus.c_cyc_i[m_g]) begin m_busy = 0; m_abort = 0; end
    end else begin
      bit tmo;
      tmo = m_timeout();
      if (!bus.c_cyc_i[m_g]) m_busy = 0;
      else if (tmo)          m_abort = 1;
      m_wdt = (bus.d_ack_i || bus.d_err_i || bus.d_rty_i) ? 0 : m_wdt + 1;
    end
  endtask

  // Inputs change at posedge+1, outputs are checked mid-cycle, and the model advances with the edge.
  task automatic cycle();
    #3;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.c_cyc_i = '0; bus.c_stb_i = '0; bus.c_we_i = '0; bus.c_dat_i = '0;
    bus.d_ack_i = 0; bus.d_err_i = 0; bus.d_rty_i = 0; bus.d_stall_i = 0;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    model_reset();

    // Reset state
    #12;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_d_cyc", bus.d_cyc_o, 1'b0);
    chk("rst_stall", bus.c_stall_o, 4'b1111);
    chk("rst_ack", bus.c_ack_o, 4'b0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round robin with all controllers requesting continuously
    for (int s = 0; s < 5; s++) begin
      bus.c_cyc_i = '1;
      cycle();
      chk("rr_grant", grant, rr_exp[s]);
      bus.d_ack_i = 1'b1;
      cycle();
      bus.d_ack_i = 1'b0;
      bus.c_cyc_i[m_g] = 1'b0;
      cycle();
    end
    bus.c_cyc_i = '0;
    cycle();

    // Routing to controller 2
    bus.c_cyc_i = 4'b0100;
    bus.c_dat_i[0] = 8'h3C;
    cycle();
    bus.c_stb_i = 4'b0100; bus.c_we_i = 4'b0100; bus.c_dat_i[2] = 8'hA5; bus.d_ack_i = 1'b1;
    #3;
    chk("route_dat", bus.d_dat_o, 8'hA5);
    chk("route_we", bus.d_we_o, 1'b1);
    chk("route_ack", bus.c_ack_o, 4'b0100);
    cycle();
    bus.c_cyc_i = '0; bus.c_stb_i = '0; bus.c_we_i = '0; bus.d_ack_i = 1'b0;
    cycle();

    // Handover: controller 1 releases while controller 3 raises cyc
    bus.c_cyc_i = 4'b0010;
    cycle();
    chk("ho_grant1", grant, 4'b0010);
    cycle();
    bus.c_cyc_i = 4'b1000;
    cycle();
    #2;
    chk("ho_idle_cyc", bus.d_cyc_o, 1'b0);
    chk("ho_idle_grant", grant, 4'b0000);
    cycle();
    chk("ho_grant3", grant, 4'b1000);

    // Stall passthrough to controller 3
    bus.c_stb_i = 4'b1000;
    bus.d_stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("stall_hi", bus.c_stall_o, 4'b1111);
      cycle();
    end
    bus.d_stall_i = 1'b0;
    #2;
    chk("stall_lo", bus.c_stall_o, 4'b0111);
    bus.c_cyc_i = '0; bus.c_stb_i = '0;
    cycle();
    cycle();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: the device never responds, so an err pulse arrives on GRANT cycle 5 and then the cycle aborts
    bus.c_cyc_i = 4'b0001; bus.c_stb_i = 4'b0001;
    cycle();
    for (int c = 1; c <= 4; c++) begin
      #2;
      chk("wdt_no_err", bus.c_err_o, 4'b0000);
      cycle();
    end
    #2;
    chk("wdt_err", bus.c_err_o, 4'b0001);
    cycle();
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("abort_cyc", bus.d_cyc_o, 1'b0);
      chk("abort_err", bus.c_err_o, 4'b0000);
      cycle();
    end
    bus.c_cyc_i = '0; bus.c_stb_i = '0;
    cycle();
    chk("abort_done", grant, 4'b0000);
`else
    // A device that never responds holds the grant indefinitely
    bus.c_cyc_i = 4'b0001; bus.c_stb_i = 4'b0001;
    for (int c = 0; c < 21; c++) cycle();
    #2;
    chk("hung_cyc", bus.d_cyc_o, 1'b1);
    chk("hung_grant", grant, 4'b0001);
    bus.c_cyc_i = '0; bus.c_stb_i = '0;
    cycle();
`endif

    // Asynchronous reset in the middle of a grant
    bus.c_cyc_i = 4'b0010;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", bus.d_cyc_o, 1'b0);
    chk("mid_rst_stall", bus.c_stall_o, 4'b1111);
    chk("mid_rst_grant", grant, 4'b0000);
    model_reset();
    bus.c_cyc_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    #2;
    chk("post_rst_grant", grant, 4'b0000);
    cycle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(3) == 0) bus.c_cyc_i[k] = ~bus.c_cyc_i[k];
      bus.c_stb_i = N'($urandom);
      bus.c_we_i  = N'($urandom);
      for (int k = 0; k < N; k++) bus.c_dat_i[k] = DW'($urandom);
      bus.d_ack_i   = ($urandom_range(3) == 0);
      bus.d_err_i   = ($urandom_range(7) == 0);
      bus.d_rty_i   = ($urandom_range(7) == 0);
      bus.d_stall_i = 1'($urandom_range(1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
